aes_controller_sequencer: RTL and testbench

Sequential half of the AES core controller. Registers the state and round codes produced by the combinational next-state logic, runs the per-state wait counter, and conditions the external `load` request. Derives the core's control strobes (`round_start`, `capture_en`, `busy`, `done`). Sits between the SPI front end and the next-state logic, forming the controller's feedback loop with that logic.

---
 rtl/aes_controller_sequencer.sv | 112 +++++++++++
 tb/tb_aes_controller_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_controller_sequencer.sv
// Sequential half of the AES controller: state/round registers, per-state wait counter, control strobes.
// Optional macro AES_LOAD_SYNC_EN adds a load synchronizer, rising-edge detector and pending flag.
module aes_controller_sequencer #(
  parameter int ROUND_WAIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] nextstate,
  input  logic [3:0] nextround,
  output logic [3:0] state,
  output logic [8:0] counter,
  output logic [3:0] round,
  output logic       load_q,
  output logic       busy,
  output logic       round_start,
  output logic       capture_en,
  output logic       done
);

  localparam logic [8:0] WAIT_INIT = 9'(ROUND_WAIT);

  logic [3:0] state_next;
  logic [3:0] round_next;
  logic [8:0] counter_next;
  logic       entering;
  logic       next_is_round;
  logic       next_is_busy;
  logic       cur_is_round;

  // Out-of-range codes from the next-state logic fall back to idle.
  always_comb begin
    state_next = 4'd0;
    round_next = 4'd0;
    if (nextstate <= 4'd12) begin
      state_next = nextstate;
      round_next = nextround;
    end
  end

  assign entering      = (state_next != state);
  assign next_is_round = (state_next >= 4'd2) && (state_next <= 4'd11);
  assign next_is_busy  = (state_next >= 4'd1) && (state_next <= 4'd11);
  assign cur_is_round  = (state >= 4'd2) && (state <= 4'd11);

  always_comb begin
    counter_next = 9'd0;
    if (entering) begin
      counter_next = next_is_round ? WAIT_INIT : 9'd0;
    end else if (cur_is_round) begin
      counter_next = (counter == 9'd0) ? 9'd0 : counter - 9'd1;
    end else if (state == 4'd12) begin
      counter_next = (counter == 9'h1FF) ? counter : counter + 9'd1;
    end
  end

  // Strobes are decoded from the value being loaded into state so they line up with it;
  // the state register itself serves as the delayed copy for entry detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= 4'd0;
      round       <= 4'd0;
      counter     <= 9'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      round_start <= 1'b0;
      capture_en  <= 1'b0;
    end else begin
      state       <= state_next;
      round       <= round_next;
      counter     <= counter_next;
      busy        <= next_is_busy;
      done        <= (state_next == 4'd12);
      round_start <= entering && next_is_busy;
      capture_en  <= entering && (state_next == 4'd12);
    end
  end

`ifdef AES_LOAD_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;
  logic pending_reg;
  logic load_edge;

  assign load_edge = sync2_reg & ~sync3_reg;

  // A new edge wins over clearing, so a request seen while leaving idle starts the following block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync3_reg   <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      sync1_reg <= load;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      if (load_edge) begin
        pending_reg <= 1'b1;
      end else if ((state == 4'd0) && (state_next != 4'd0)) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign load_q = pending_reg;
`else
  assign load_q = load;
`endif

endmodule

// File: tb/tb_aes_controller_sequencer.sv
// Bench for aes_controller_sequencer: models the next-state logic around two instances (ROUND_WAIT 3 and 1)
// and compares per-cycle output traces against a queue of expected vectors.
module tb_aes_controller_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic [8:0] cnt;
    logic [3:0] rnd;
    logic       bsy;
    logic       rs;
    logic       cap;
    logic       dn;
  } vec_t;

`ifdef AES_LOAD_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_a = 1'b0;
  logic load_b = 1'b0;
  logic sel = 1'b0;

  logic [3:0] a_state, a_round, a_ns, a_nr, b_state, b_round, b_ns, b_nr;
  logic [8:0] a_counter, b_counter;
  logic a_load_q, a_busy, a_rs, a_cap, a_done;
  logic b_load_q, b_busy, b_rs, b_cap, b_done;
  vec_t obs;

  int vectors = 0;
  int miscompares = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] ns_f(input logic [3:0] s, input logic [8:0] c, input logic lq);
    logic [3:0] r;
    r = 4'd0;
    if (s == 4'd0)                    r = lq ? 4'd1 : 4'd0;
    else if (s == 4'd1)               r = 4'd2;
    else if (s >= 4'd2 && s <= 4'd11) r = (c == 9'd1) ? s + 4'd1 : s;
    else if (s == 4'd12)              r = (c == 9'h1FF) ? 4'd0 : 4'd12;
    return r;
  endfunction

  function automatic logic [3:0] nr_f(input logic [3:0] ns);
    return (ns >= 4'd2 && ns <= 4'd11) ? ns - 4'd1 : 4'd0;
  endfunction

  assign a_ns = ns_f(a_state, a_counter, a_load_q);
  assign a_nr = nr_f(a_ns);
  assign b_ns = ns_f(b_state, b_counter, b_load_q);
  assign b_nr = nr_f(b_ns);

  aes_controller_sequencer #(.ROUND_WAIT(3)) u_a (
    .clk(clk), .reset(reset), .load(load_a), .nextstate(a_ns), .nextround(a_nr),
    .state(a_state), .counter(a_counter), .round(a_round), .load_q(a_load_q),
    .busy(a_busy), .round_start(a_rs), .capture_en(a_cap), .done(a_done)
  );

  aes_controller_sequencer #(.ROUND_WAIT(1)) u_b (
    .clk(clk), .reset(reset), .load(load_b), .nextstate(b_ns), .nextround(b_nr),
    .state(b_state), .counter(b_counter), .round(b_round), .load_q(b_load_q),
    .busy(b_busy), .round_start(b_rs), .capture_en(b_cap), .done(b_done)
  );

  always_comb begin
    obs = '0;
    if (sel) obs = '{b_state, b_counter, b_round, b_busy, b_rs, b_cap, b_done};
    else     obs = '{a_state, a_counter, a_round, a_busy, a_rs, a_cap, a_done};
  end

  task automatic push_block(input int rw, input int idles);
    exp_q.push_back('{4'd1, 9'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int s = 2; s <= 11; s++)
      for (int k = 0; k < rw; k++)
        exp_q.push_back('{4'(s), 9'(rw - k), 4'(s - 1), 1'b1, (k == 0), 1'b0, 1'b0});
    for (int k = 0; k < 512; k++)
      exp_q.push_back('{4'd12, 9'(k), 4'd0, 1'b0, 1'b0, (k == 0), 1'b1});
    for (int i = 0; i <= idles; i++)
      exp_q.push_back('0);
  endtask

  task automatic start_block(input logic hold, input string tag);
    int lat = 0;
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) begin load_a = 1'b0; load_b = 1'b0; end
    end while (obs.st !== 4'd1 && lat < 12);
    vectors++;
    if (obs.st !== 4'd1 || lat != EXP_LAT) begin
      $display("FAIL %s latency: got %0d cycles (state=%0d), required %0d cycles to state 1", tag, lat, obs.st, EXP_LAT);
      miscompares++;
    end
  endtask

  // Pops one expected vector per cycle; optionally pulses or drops load_a at given trace indices.
  task automatic run_trace(input string tag, input int pulse_at, input int drop_at);
    int idx = 0;
    vec_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (pulse_at >= 0 && idx == pulse_at) load_a = 1'b1;
      if ((pulse_at >= 0 && idx == pulse_at + 1) || idx == drop_at) load_a = 1'b0;
      vectors++;
      if (obs !== e) begin
        $display("FAIL %s[%0d]: got st=%0d cnt=%0d rnd=%0d b/rs/cap/dn=%b%b%b%b, required st=%0d cnt=%0d rnd=%0d b/rs/cap/dn=%b%b%b%b",
                 tag, idx, obs.st, obs.cnt, obs.rnd, obs.bsy, obs.rs, obs.cap, obs.dn,
                 e.st, e.cnt, e.rnd, e.bsy, e.rs, e.cap, e.dn);
        miscompares++;
      end
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({a_state, a_counter, a_round, a_load_q, a_busy, a_rs, a_cap, a_done} !== '0) begin
      $display("FAIL %s A: got st=%0d cnt=%0d rnd=%0d lq/b/rs/cap/dn=%b%b%b%b%b, required all 0",
               tag, a_state, a_counter, a_round, a_load_q, a_busy, a_rs, a_cap, a_done);
      miscompares++;
    end
    vectors++;
    if ({b_state, b_counter, b_round, b_load_q, b_busy, b_rs, b_cap, b_done} !== '0) begin
      $display("FAIL %s B: got st=%0d cnt=%0d rnd=%0d lq/b/rs/cap/dn=%b%b%b%b%b, required all 0",
               tag, b_state, b_counter, b_round, b_load_q, b_busy, b_rs, b_cap, b_done);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");
    $display("test_reset done: %0d vectors so far", vectors);
  endtask

  task automatic test_block_rw3;
    sel = 1'b0;
    start_block(1'b0, "rw3");
    push_block(3, 2);
    run_trace("rw3", -1, -1);
    $display("test_block_rw3 done: %0d vectors so far", vectors);
  endtask

  task automatic test_block_rw1;
    sel = 1'b1;
    start_block(1'b0, "rw1");
    push_block(1, 2);
    run_trace("rw1", -1, -1);
    sel = 1'b0;
    $display("test_block_rw1 done: %0d vectors so far", vectors);
  endtask

  task automatic test_reset_midblock;
    int n = 0;
    sel = 1'b0;
    start_block(1'b0, "abort");
    while (a_state !== 4'd6 && n < 40) begin @(negedge clk); n++; end
    vectors++;
    if (a_state !== 4'd6) begin
      $display("FAIL abort_wait: got state=%0d, required 6 within 40 cycles", a_state);
      miscompares++;
    end
    reset = 1'b1;
    #1;
    check_all_zero("abort_async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (a_cap !== 1'b0 || a_done !== 1'b0 || a_state !== 4'd0) begin
        $display("FAIL abort_quiet[%0d]: got st=%0d cap=%b done=%b, required 0 0 0", i, a_state, a_cap, a_done);
        miscompares++;
      end
    end
    start_block(1'b0, "after_abort");
    push_block(3, 2);
    run_trace("after_abort", -1, -1);
    $display("test_reset_midblock done: %0d vectors so far", vectors);
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
`ifdef AES_LOAD_SYNC_EN
    // Single pulse during state 8 (trace index 19) queues exactly one more block.
    start_block(1'b0, "pending");
    push_block(3, 0);
    push_block(3, 3);
    run_trace("pending", 19, -1);
`else
    // Level held high restarts after one idle cycle; dropped during the second block's state 1.
    start_block(1'b1, "level");
    push_block(3, 0);
    push_block(3, 3);
    run_trace("level", -1, 544);
`endif
    load_a = 1'b0;
    $display("test_back_to_back done: %0d vectors so far", vectors);
  endtask

  initial begin
    test_reset;
    test_block_rw3;
    test_block_rw1;
    test_reset_midblock;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
